// File: rtl/video_stream_capture_sink.sv
// video_stream_capture_sink
// Consumer end of the {rgb, frame_start} pixel stream. Pulls words at a fixed
// rate (one ready cycle in every READY_DIV), and when armed over the slot bus
// captures one complete frame, producing a CRC-16-CCITT and a pixel count.
//
// Optional build macro: VIDEO_SINK_STATS_EN adds a 20-bit underrun counter
// (ready cycles without valid while capturing), readable at addr 4.
//
// Handshake: a word moves when si_valid and si_ready are both high at a rising
// clk edge. The source keeps si_data stable while si_valid is high and the word
// has not been taken; si_ready depends only on the free-running divider, never
// on si_valid or on the capture state.
module video_stream_capture_sink #(
   parameter int CD        = 12,
   parameter int HMAX      = 640,
   parameter int VMAX      = 480,
   parameter int READY_DIV = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [13:0]   addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data,
   input  logic [CD:0]   si_data,
   input  logic          si_valid,
   output logic          si_ready,
   output logic          done
);

   localparam int              FRAME     = HMAX * VMAX;
   localparam logic [19:0]     FRAME_CNT = 20'(FRAME);
   localparam int              DIV_W     = (READY_DIV > 1) ? $clog2(READY_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(READY_DIV - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      CAPTURE  = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div;
   logic [15:0]      crc;
   logic [19:0]      count;
   logic             err_sof;
   logic             err_len;

   logic             arm;
   logic             clr;
   logic             xfer;
   logic             busy;
   logic             sof;
   logic [CD-1:0]    pixel;
   logic [15:0]      crc_seed;
   logic [15:0]      crc_next;
   logic [19:0]      count_inc;

   // Bus strobes and address bits above the decoded range carry no meaning here.
   logic             unused_bits;
   assign unused_bits = ^{read, addr[13:3], wr_data[31:2]};

   // One CRC-16-CCITT update over a whole pixel, MSB first, fully unrolled.
   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [CD-1:0] px);
      logic [15:0] r;
      r = c;
      for (int i = CD - 1; i >= 0; i--) begin
         if (r[15] ^ px[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else               r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   assign pixel     = si_data[CD:1];
   assign sof       = si_data[0];
   assign xfer      = si_valid & si_ready;
   assign arm       = cs & write & (addr[2:0] == 3'd0) & wr_data[0];
   assign clr       = cs & write & (addr[2:0] == 3'd0) & wr_data[1];
   assign busy      = (state == WAIT_SOF) || (state == CAPTURE);
   assign crc_seed  = crc16_step(16'hFFFF, pixel);
   assign crc_next  = crc16_step(crc, pixel);
   assign count_inc = count + 20'd1;

   // Free-running pull-rate divider; si_ready is the registered decode of its last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         div      <= '0;
         si_ready <= 1'b0;
      end else begin
         si_ready <= (div == DIV_LAST);
         div      <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end
   end

   // Capture FSM: arm restarts from any state and wins over a same-cycle transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         crc     <= 16'hFFFF;
         count   <= '0;
         err_sof <= 1'b0;
         err_len <= 1'b0;
         done    <= 1'b0;
      end else begin
         if (clr) begin
            err_sof <= 1'b0;
            err_len <= 1'b0;
         end
         if (arm) begin
            crc   <= 16'hFFFF;
            count <= '0;
            done  <= 1'b0;
            state <= WAIT_SOF;
         end else begin
            case (state)
               IDLE: begin
               end
               WAIT_SOF: begin
                  if (xfer && sof) begin
                     crc   <= crc_seed;
                     count <= 20'd1;
                     if (FRAME_CNT == 20'd1) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        state <= CAPTURE;
                     end
                  end
               end
               CAPTURE: begin
                  if (xfer) begin
                     if (sof) begin
                        // A new frame started early: stop with the partial result.
                        err_sof <= 1'b1;
                        err_len <= (count != FRAME_CNT);
                        done    <= 1'b1;
                        state   <= DONE;
                     end else begin
                        crc   <= crc_next;
                        count <= count_inc;
                        if (count_inc == FRAME_CNT) begin
                           done  <= 1'b1;
                           state <= DONE;
                        end
                     end
                  end
               end
               DONE: begin
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef VIDEO_SINK_STATS_EN
   logic [19:0] underrun;

   // Count ready slots the source left empty during a capture.
   always_ff @(posedge clk) begin
      if (reset || arm)                                  underrun <= '0;
      else if (state == CAPTURE && si_ready && !si_valid) underrun <= underrun + 20'd1;
   end
`endif

   // Register read mux, purely combinational from the address.
   always_comb begin
      rd_data = '0;
      case (addr[2:0])
         3'd1:    rd_data = {29'b0, err_len, err_sof, busy};
         3'd2:    rd_data = {16'b0, crc};
         3'd3:    rd_data = {12'b0, count};
`ifdef VIDEO_SINK_STATS_EN
         3'd4:    rd_data = {12'b0, underrun};
`endif
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_video_stream_capture_sink.sv
// tb_video_stream_capture_sink
// Two sinks on one clock: a fast one (READY_DIV=1) and a paced one
// (READY_DIV=4), both with a 4x2 frame. A frame-level reference model follows
// every accepted word and predicts crc, count, flags and underruns.
module tb_video_stream_capture_sink;

   localparam int FRAME = 8;

   logic        clk;
   logic        rst      [2];
   logic        cs       [2];
   logic        read     [2];
   logic        write    [2];
   logic [13:0] addr     [2];
   logic [31:0] wr_data  [2];
   logic [31:0] rd_data  [2];
   logic [12:0] si_data  [2];
   logic        si_valid [2];
   logic        si_ready [2];
   logic        done     [2];

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0] m_crc;
   int          m_count;
   int          m_under;
   bit          m_waiting, m_capturing, m_done, m_err_sof, m_err_len;
   logic [15:0] clean_crc;
   logic [12:0] src_q[$];

   video_stream_capture_sink #(.CD(12), .HMAX(4), .VMAX(2), .READY_DIV(1)) dut_fast (
      .clk(clk), .reset(rst[0]), .cs(cs[0]), .read(read[0]), .write(write[0]),
      .addr(addr[0]), .wr_data(wr_data[0]), .rd_data(rd_data[0]),
      .si_data(si_data[0]), .si_valid(si_valid[0]), .si_ready(si_ready[0]), .done(done[0]));

   video_stream_capture_sink #(.CD(12), .HMAX(4), .VMAX(2), .READY_DIV(4)) dut_slow (
      .clk(clk), .reset(rst[1]), .cs(cs[1]), .read(read[1]), .write(write[1]),
      .addr(addr[1]), .wr_data(wr_data[1]), .rd_data(rd_data[1]),
      .si_data(si_data[1]), .si_valid(si_valid[1]), .si_ready(si_ready[1]), .done(done[1]));

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int rd_div(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   // CCITT CRC over a 12-bit pixel: fold the pixel into the top bits, then divide.
   function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [11:0] px);
      logic [15:0] r;
      r = c ^ {px, 4'b0};
      for (int b = 0; b < 12; b++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   task automatic model_reset();
      m_crc = 16'hFFFF; m_count = 0; m_under = 0;
      m_waiting = 0; m_capturing = 0; m_done = 0; m_err_sof = 0; m_err_len = 0;
   endtask

   task automatic model_arm();
      m_crc = 16'hFFFF; m_count = 0; m_under = 0;
      m_waiting = 1; m_capturing = 0; m_done = 0;
   endtask

   task automatic model_xfer(input logic [12:0] w);
      logic [11:0] px;
      logic        fs;
      px = w[12:1];
      fs = w[0];
      if (m_capturing) begin
         if (fs) begin
            m_err_sof = 1; m_err_len = (m_count != FRAME); m_capturing = 0; m_done = 1;
         end else begin
            m_crc = ref_crc(m_crc, px);
            m_count++;
            if (m_count == FRAME) begin m_capturing = 0; m_done = 1; end
         end
      end else if (m_waiting && fs) begin
         m_crc = ref_crc(16'hFFFF, px); m_count = 1; m_waiting = 0; m_capturing = 1;
      end
   endtask

   // Driver tasks: all start and end just after a falling edge.
   task automatic idle_inputs(input int d);
      cs[d] = 0; read[d] = 0; write[d] = 0; addr[d] = '0; wr_data[d] = '0;
      si_valid[d] = 0; si_data[d] = '0;
   endtask

   task automatic bus_read(input int d, input logic [2:0] a, output logic [31:0] q);
      cs[d] = 1; read[d] = 1; write[d] = 0; addr[d] = {11'b0, a};
      #1;
      q = rd_data[d];
      cs[d] = 0; read[d] = 0; addr[d] = '0;
   endtask

   task automatic do_write(input int d, input logic [31:0] data);
      bit under;
      cs[d] = 1; write[d] = 1; addr[d] = '0; wr_data[d] = data; si_valid[d] = 0;
      under = m_capturing && si_ready[d];
      @(negedge clk);
      idle_inputs(d);
      if (data[1]) begin m_err_sof = 0; m_err_len = 0; end
      if (data[0]) model_arm();
      else if (under) m_under++;
   endtask

   // Offer src_q in order; each word waits for ready, then 'gap' idle cycles follow
   // (gap < 0 picks a random gap per word). arm_at injects an arm with that word.
   task automatic stream(input int d, input int gap, input int arm_at);
      int  idx = 0, wait_n = 0, guard = 0, limit;
      bit  armed_done = 0, v, arm, rdy, xfer, under;
      limit = src_q.size() * 16 + 40;
      while (idx < src_q.size()) begin
         v   = (wait_n == 0);
         arm = (idx == arm_at) && !armed_done;
         si_valid[d] = v; si_data[d] = src_q[idx];
         cs[d] = arm; write[d] = arm; addr[d] = '0; wr_data[d] = arm ? 32'h1 : 32'h0;
         rdy   = si_ready[d];
         xfer  = v && rdy;
         under = m_capturing && rdy && !v;
         @(negedge clk);
         if (arm) begin
            model_arm();
            armed_done = 1;
         end else begin
            if (xfer)  model_xfer(src_q[idx]);
            if (under) m_under++;
         end
         if (xfer) begin
            idx++;
            wait_n = (gap < 0) ? int'($urandom_range(0, 9)) : gap;
         end else if (wait_n > 0) begin
            wait_n--;
         end
         guard++;
         if (guard > limit) begin
            checks++; errors++;
            $display("FAIL stream_timeout got %0d words taken exp %0d", idx, src_q.size());
            break;
         end
      end
      idle_inputs(d);
   endtask

   task automatic fill_frame(input bit rand_px, input int n);
      src_q = {};
      for (int i = 0; i < n; i++)
         src_q.push_back({rand_px ? 12'($urandom_range(0, 4095)) : 12'h008, (i == 0)});
   endtask

   // Scenario tasks
   task automatic test_reset(input int d);
      logic [31:0] q;
      idle_inputs(d);
      @(negedge clk);
      rst[d] = 1;
      repeat (3) @(negedge clk);
      rst[d] = 0;
      model_reset();
      bus_read(d, 3'd1, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp %h", q, 32'h0); end
      bus_read(d, 3'd2, q);
      checks++; if (q !== 32'h0000FFFF) begin errors++; $display("FAIL reset_crc got %h exp %h", q, 32'h0000FFFF); end
      bus_read(d, 3'd3, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp %h", q, 32'h0); end
      checks++; if (done[d] !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done[d]); end
      checks++; if (si_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", si_ready[d]); end
   endtask

   task automatic test_ready_pattern(input int d);
      logic exp;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp = ((k % rd_div(d)) == 0);
         checks++;
         if (si_ready[d] !== exp) begin
            errors++; $display("FAIL ready_pattern cycle %0d got %b exp %b", k, si_ready[d], exp);
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] q;
      do_write(0, 32'h1);
      fill_frame(0, 7);
      stream(0, 0, -1);
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL basic_done_early got %b exp 0", done[0]); end
      src_q = {{12'h008, 1'b0}};
      stream(0, 0, -1);
      checks++; if (done[0] !== m_done) begin errors++; $display("FAIL basic_done got %b exp %b", done[0], m_done); end
      bus_read(0, 3'd3, q);
      checks++; if (q !== 32'd8) begin errors++; $display("FAIL basic_count got %0d exp 8", q); end
      bus_read(0, 3'd2, q);
      checks++; if (q !== {16'b0, m_crc}) begin errors++; $display("FAIL basic_crc got %h exp %h", q, m_crc); end
      bus_read(0, 3'd1, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL basic_status got %h exp %h", q, 32'h0); end
      clean_crc = m_crc;
      fill_frame(0, FRAME);
      stream(0, 0, -1);
      bus_read(0, 3'd3, q);
      checks++; if (q !== 32'd8) begin errors++; $display("FAIL second_frame_count got %0d exp 8", q); end
      bus_read(0, 3'd2, q);
      checks++; if (q !== {16'b0, clean_crc}) begin errors++; $display("FAIL second_frame_crc got %h exp %h", q, clean_crc); end
      bus_read(0, 3'd0, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL addr0_read got %h exp 0", q); end
      bus_read(0, 3'd7, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL addr7_read got %h exp 0", q); end
   endtask

   task automatic test_arm_mid_frame();
      logic [31:0] q;
      do_write(0, 32'h1);
      fill_frame(0, FRAME);
      for (int i = 0; i < FRAME; i++) src_q.push_back({12'h008, (i == 0)});
      stream(0, 0, 3);
      checks++; if (done[0] !== m_done) begin errors++; $display("FAIL midarm_done got %b exp %b", done[0], m_done); end
      bus_read(0, 3'd3, q);
      checks++; if (q !== 32'(m_count)) begin errors++; $display("FAIL midarm_count got %0d exp %0d", q, m_count); end
      bus_read(0, 3'd2, q);
      checks++; if (q !== {16'b0, clean_crc}) begin errors++; $display("FAIL midarm_crc got %h exp %h", q, clean_crc); end
   endtask

   task automatic test_early_sof();
      logic [31:0] q;
      do_write(0, 32'h1);
      fill_frame(1, 5);
      src_q.push_back({12'($urandom_range(0, 4095)), 1'b1});
      stream(0, 0, -1);
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL early_done got %b exp 1", done[0]); end
      bus_read(0, 3'd3, q);
      checks++; if (q !== 32'd5) begin errors++; $display("FAIL early_count got %0d exp 5", q); end
      bus_read(0, 3'd2, q);
      checks++; if (q !== {16'b0, m_crc}) begin errors++; $display("FAIL early_crc got %h exp %h", q, m_crc); end
      bus_read(0, 3'd1, q);
      checks++;
      if (q !== {29'b0, m_err_len, m_err_sof, m_waiting | m_capturing}) begin
         errors++; $display("FAIL early_status got %h exp %h", q, {29'b0, m_err_len, m_err_sof, 1'b0});
      end
      do_write(0, 32'h2);
      bus_read(0, 3'd1, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL clear_status got %h exp 0", q); end
      bus_read(0, 3'd3, q);
      checks++; if (q !== 32'd5) begin errors++; $display("FAIL clear_count got %0d exp 5", q); end
   endtask

   task automatic test_reset_mid_capture();
      logic [31:0] q;
      do_write(0, 32'h1);
      fill_frame(1, 3);
      stream(0, 0, -1);
      bus_read(0, 3'd1, q);
      checks++; if (q !== 32'h1) begin errors++; $display("FAIL midcap_busy got %h exp 1", q); end
      rst[0] = 1;
      @(negedge clk);
      rst[0] = 0;
      model_reset();
      bus_read(0, 3'd1, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL midrst_status got %h exp 0", q); end
      bus_read(0, 3'd2, q);
      checks++; if (q !== 32'h0000FFFF) begin errors++; $display("FAIL midrst_crc got %h exp %h", q, 32'h0000FFFF); end
      bus_read(0, 3'd3, q);
      checks++; if (q !== 32'h0) begin errors++; $display("FAIL midrst_count got %h exp 0", q); end
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done[0]); end
      do_write(0, 32'h1);
      fill_frame(1, FRAME);
      stream(0, 0, -1);
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL rearm_done got %b exp 1", done[0]); end
      bus_read(0, 3'd3, q);
      checks++; if (q !== 32'd8) begin errors++; $display("FAIL rearm_count got %0d exp 8", q); end
      bus_read(0, 3'd2, q);
      checks++; if (q !== {16'b0, m_crc}) begin errors++; $display("FAIL rearm_crc got %h exp %h", q, m_crc); end
   endtask

   task automatic test_underrun(input int gap);
      logic [31:0] q, exp;
      do_write(1, 32'h1);
      fill_frame(1, FRAME);
      stream(1, gap, -1);
      checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL paced_done got %b exp 1", done[1]); end
      bus_read(1, 3'd3, q);
      checks++; if (q !== 32'd8) begin errors++; $display("FAIL paced_count got %0d exp 8", q); end
      bus_read(1, 3'd2, q);
      checks++; if (q !== {16'b0, m_crc}) begin errors++; $display("FAIL paced_crc got %h exp %h", q, m_crc); end
`ifdef VIDEO_SINK_STATS_EN
      exp = 32'(m_under);
`else
      exp = 32'h0;
`endif
      bus_read(1, 3'd4, q);
      checks++; if (q !== exp) begin errors++; $display("FAIL underrun got %0d exp %0d", q, exp); end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1;
         idle_inputs(d);
      end
      model_reset();
      clean_crc = 16'hFFFF;
      test_reset(0);
      test_ready_pattern(0);
      test_basic();
      test_arm_mid_frame();
      test_early_sof();
      test_reset_mid_capture();
      test_reset(1);
      test_ready_pattern(1);
      test_underrun(7);
      test_underrun(-1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
